// File: rtl/chan_scan_pkg.sv
// chan_scan_pkg -- shared types and constants for the channel scan controller.
//   state_t : scan FSM encoding (IDLE / SCAN / PAUSE)
//   NCH     : number of scanned channels
//   SEL_W   : width of a channel index
package chan_scan_pkg;

   localparam int NCH   = 4;
   localparam int SEL_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SCAN  = 2'b01,
      PAUSE = 2'b10
   } state_t;

endpackage

// File: rtl/chan_next_sel.sv
// chan_next_sel -- combinational next-enabled-channel picker.
//   cur       in  : current channel index
//   skip_mask in  : bit i = 1 removes channel i from the rotation
//   nxt       out : first enabled channel after cur, searching cur+1 .. cur+NCH (mod NCH)
//   wrap      out : nxt <= cur, i.e. the rotation passed back over the top
//   none      out : every channel is masked; nxt is meaningless
// Because the search window ends at cur itself, a single enabled channel
// selects itself and reports a wrap on every advance.
module chan_next_sel
   import chan_scan_pkg::*;
(
   input  logic [SEL_W-1:0] cur,
   input  logic [NCH-1:0]   skip_mask,
   output logic [SEL_W-1:0] nxt,
   output logic             wrap,
   output logic             none
);

   logic [SEL_W-1:0] cand [NCH];
   logic [NCH-1:0]   ok;

   // Candidate gi is the channel gi+1 steps ahead; index arithmetic wraps mod NCH.
   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_cand
         assign cand[gi] = cur + SEL_W'(gi + 1);
         assign ok[gi]   = ~skip_mask[cand[gi]];
      end
   endgenerate

   // Nearest enabled candidate wins: scan from farthest to nearest so the
   // nearest assignment is the last one made.
   always_comb begin
      nxt = cur;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (ok[k]) nxt = cand[k];
      end
   end

   assign none = ~|ok;
   assign wrap = ~none && (nxt <= cur);

endmodule

// File: rtl/chan_scan_ctrl.sv
// chan_scan_ctrl -- rotating channel scanner driving a downstream 2-to-4 decoder.
//   clk, rst_n  in  : clock, asynchronous active-low reset
//   start       in  : begin a scan (only looked at while idle)
//   stop        in  : abort, wins over everything else
//   pause       in  : level, freezes the scan while high
//   oneshot     in  : level, 1 = one sweep then idle, 0 = continuous
//   dwell       in  : each channel is held dwell+1 cycles; sampled at every reload
//   skip_mask   in  : per-channel skip (only when CHAN_SKIP_EN is defined)
//   en, in      out : registered decoder enable and channel index
//   busy        out : scan in progress (SCAN or PAUSE)
//   done        out : one-cycle pulse at the end of a oneshot sweep
//   wrap        out : one-cycle pulse when the index wraps to the first enabled channel
// Build option: define CHAN_SKIP_EN to add the skip_mask port; otherwise all
// channels are scanned in order 0..NCH-1.
module chan_scan_ctrl
   import chan_scan_pkg::*;
#(
   parameter int DWELL_W = 8
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               pause,
   input  logic               oneshot,
   input  logic [DWELL_W-1:0] dwell,
`ifdef CHAN_SKIP_EN
   input  logic [NCH-1:0]     skip_mask,
`endif
   output logic               en,
   output logic [SEL_W-1:0]   in,
   output logic               busy,
   output logic               done,
   output logic               wrap
);

   state_t             state_reg, state_next;
   logic [DWELL_W-1:0] cnt_reg, cnt_next;
   logic               en_reg, en_next;
   logic [SEL_W-1:0]   in_reg, in_next;
   logic               busy_reg, busy_next;
   logic               done_reg, done_next;
   logic               wrap_reg, wrap_next;

   logic [NCH-1:0]     mask;
   logic [SEL_W-1:0]   sel_cur, nx_sel;
   logic               nx_wrap, nx_none;

`ifdef CHAN_SKIP_EN
   assign mask = skip_mask;
`else
   assign mask = '0;
`endif

   // While idle, searching forward from the last channel yields the first
   // enabled channel, so one selector serves both start and advance.
   assign sel_cur = (state_reg == IDLE) ? SEL_W'(NCH - 1) : in_reg;

   chan_next_sel u_next_sel (
      .cur       (sel_cur),
      .skip_mask (mask),
      .nxt       (nx_sel),
      .wrap      (nx_wrap),
      .none      (nx_none)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         en_reg    <= 1'b0;
         in_reg    <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         wrap_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         en_reg    <= en_next;
         in_reg    <= in_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         wrap_reg  <= wrap_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      en_next    = en_reg;
      in_next    = in_reg;
      busy_next  = busy_reg;
      done_next  = 1'b0;
      wrap_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start && !stop && !nx_none) begin
               state_next = SCAN;
               en_next    = 1'b1;
               in_next    = nx_sel;
               cnt_next   = dwell;
               busy_next  = 1'b1;
            end
         end

         // The cycle on which pause is sampled does not consume count; the
         // step it skipped is taken on the resume edge instead. That keeps
         // in and the counter frozen during PAUSE while each channel still
         // sees exactly dwell+1 enabled cycles.
         SCAN, PAUSE: begin
            if (stop) begin
               state_next = IDLE;
               en_next    = 1'b0;
               in_next    = '0;
               cnt_next   = '0;
               busy_next  = 1'b0;
            end else if (pause) begin
               state_next = PAUSE;
               en_next    = 1'b0;
            end else begin
               state_next = SCAN;
               en_next    = 1'b1;
               if (cnt_reg != '0) begin
                  cnt_next = cnt_reg - DWELL_W'(1);
               end else if (nx_none || (nx_wrap && oneshot)) begin
                  // All channels masked mid-scan, or a oneshot sweep is complete.
                  state_next = IDLE;
                  en_next    = 1'b0;
                  in_next    = '0;
                  cnt_next   = '0;
                  busy_next  = 1'b0;
                  done_next  = !nx_none;
                  wrap_next  = !nx_none;
               end else begin
                  in_next   = nx_sel;
                  cnt_next  = dwell;
                  wrap_next = nx_wrap;
               end
            end
         end

         default: begin
            state_next = IDLE;
            en_next    = 1'b0;
            in_next    = '0;
            cnt_next   = '0;
            busy_next  = 1'b0;
         end
      endcase
   end

   assign en   = en_reg;
   assign in   = in_reg;
   assign busy = busy_reg;
   assign done = done_reg;
   assign wrap = wrap_reg;

endmodule

// File: tb/tb_chan_scan_ctrl.sv
// tb_chan_scan_ctrl -- table-driven self-checking bench for chan_scan_ctrl.
// Each record holds the inputs for n consecutive cycles and the outputs
// expected after each of those clock edges, packed as {en, in, busy, done, wrap}.
module tb_chan_scan_ctrl;
   import chan_scan_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0, stop = 1'b0, pause = 1'b0, oneshot = 1'b0;
   logic [7:0] dwell = 8'd0;
   logic [3:0] skip_mask = 4'd0;
   logic       en, busy, done, wrap;
   logic [1:0] in;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   chan_scan_ctrl #(.DWELL_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .pause     (pause),
      .oneshot   (oneshot),
      .dwell     (dwell),
`ifdef CHAN_SKIP_EN
      .skip_mask (skip_mask),
`endif
      .en        (en),
      .in        (in),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap)
   );

   typedef struct {
      string      tag;
      logic       st, sp, pa, os;
      logic [7:0] dw;
      logic [3:0] sk;
      int         n;
      logic [5:0] exp;
   } vec_t;

   vec_t       vecs[$];
   logic [5:0] exp_q[$];

   localparam logic [5:0] ZERO = 6'b000000;
   localparam logic [5:0] DONE = 6'b000011;

   function automatic logic [5:0] sc(int c, bit w);
      logic [1:0] ci = 2'(c);
      return {1'b1, ci, 1'b1, 1'b0, w};
   endfunction

   function automatic logic [5:0] pz(int c);
      logic [1:0] ci = 2'(c);
      return {1'b0, ci, 1'b1, 1'b0, 1'b0};
   endfunction

   function automatic vec_t v(string tag, bit st, bit sp, bit pa, bit os,
                              int dw, logic [3:0] sk, int n, logic [5:0] e);
      vec_t r;
      r.tag = tag; r.st = st; r.sp = sp; r.pa = pa; r.os = os;
      r.dw = 8'(dw); r.sk = sk; r.n = n; r.exp = e;
      return r;
   endfunction

   task automatic check(string tag, logic [5:0] expv);
      logic [5:0] act;
      act = {en, in, busy, done, wrap};
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got {en,in,busy,done,wrap}=%b want %b at %0t", tag, act, expv, $time);
      end
   endtask

   task automatic apply(vec_t r);
      for (int c = 0; c < r.n; c++) begin
         @(negedge clk);
         start = r.st; stop = r.sp; pause = r.pa; oneshot = r.os;
         dwell = r.dw; skip_mask = r.sk;
         exp_q.push_back(r.exp);
         @(posedge clk);
         #1;
         check(r.tag, exp_q.pop_front());
      end
      $display("vec %-14s st=%0b sp=%0b pa=%0b os=%0b dw=%0d sk=%b x%0d -> en=%0b in=%0d busy=%0b done=%0b wrap=%0b",
               r.tag, r.st, r.sp, r.pa, r.os, r.dw, r.sk, r.n, en, in, busy, done, wrap);
   endtask

   initial begin
      // Oneshot sweep, dwell=2: three cycles per channel, then done+wrap together.
      vecs.push_back(v("os_start", 1,0,0,1, 2,4'h0, 1, sc(0,0)));
      vecs.push_back(v("os_ch0",   0,0,0,1, 2,4'h0, 2, sc(0,0)));
      vecs.push_back(v("os_ch1",   0,0,0,1, 2,4'h0, 3, sc(1,0)));
      vecs.push_back(v("os_ch2",   0,0,0,1, 2,4'h0, 3, sc(2,0)));
      vecs.push_back(v("os_ch3",   0,0,0,1, 2,4'h0, 3, sc(3,0)));
      vecs.push_back(v("os_done",  0,0,0,1, 2,4'h0, 1, DONE));
      vecs.push_back(v("os_idle",  0,0,0,1, 2,4'h0, 2, ZERO));
      // Continuous, dwell=0: one cycle per channel, wrap every fourth cycle.
      vecs.push_back(v("ct_start", 1,0,0,0, 0,4'h0, 1, sc(0,0)));
      for (int i = 1; i <= 8; i++)
         vecs.push_back(v("ct_run", 0,0,0,0, 0,4'h0, 1, sc(i % 4, (i % 4) == 0)));
      vecs.push_back(v("ct_stop",  0,1,0,0, 0,4'h0, 2, ZERO));
      // Oneshot with dwell=0.
      vecs.push_back(v("os0_start",1,0,0,1, 0,4'h0, 1, sc(0,0)));
      vecs.push_back(v("os0_ch1",  0,0,0,1, 0,4'h0, 1, sc(1,0)));
      vecs.push_back(v("os0_ch2",  0,0,0,1, 0,4'h0, 1, sc(2,0)));
      vecs.push_back(v("os0_ch3",  0,0,0,1, 0,4'h0, 1, sc(3,0)));
      vecs.push_back(v("os0_done", 0,0,0,1, 0,4'h0, 1, DONE));
      // Pause for 4 cycles on the 2nd cycle of channel 1, dwell=5.
      vecs.push_back(v("pz_start", 1,0,0,0, 5,4'h0, 1, sc(0,0)));
      vecs.push_back(v("pz_ch0",   0,0,0,0, 5,4'h0, 5, sc(0,0)));
      vecs.push_back(v("pz_ch1a",  0,0,0,0, 5,4'h0, 2, sc(1,0)));
      vecs.push_back(v("pz_hold",  0,0,1,0, 5,4'h0, 4, pz(1)));
      vecs.push_back(v("pz_ch1b",  0,0,0,0, 5,4'h0, 4, sc(1,0)));
      vecs.push_back(v("pz_ch2",   0,0,0,0, 5,4'h0, 1, sc(2,0)));
      vecs.push_back(v("pz_stop",  0,1,0,0, 5,4'h0, 1, ZERO));
      // Stop with pause, start with stop, stop from PAUSE.
      vecs.push_back(v("sp_start", 1,0,0,0, 3,4'h0, 2, sc(0,0)));
      vecs.push_back(v("sp_stppz", 0,1,1,0, 3,4'h0, 1, ZERO));
      vecs.push_back(v("sp_ststp", 1,1,0,0, 3,4'h0, 2, ZERO));
      vecs.push_back(v("sp_again", 1,0,0,0, 3,4'h0, 1, sc(0,0)));
      vecs.push_back(v("sp_pause", 0,0,1,0, 3,4'h0, 2, pz(0)));
      vecs.push_back(v("sp_pzstp", 0,1,1,0, 3,4'h0, 1, ZERO));
      // Start while busy is ignored.
      vecs.push_back(v("sb_start", 1,0,0,0, 1,4'h0, 2, sc(0,0)));
      vecs.push_back(v("sb_held",  1,0,0,0, 1,4'h0, 2, sc(1,0)));
      vecs.push_back(v("sb_stop",  0,1,0,0, 1,4'h0, 1, ZERO));
      // Dwell change only takes effect at the next reload.
      vecs.push_back(v("dw_start", 1,0,0,0, 3,4'h0, 1, sc(0,0)));
      vecs.push_back(v("dw_ch0",   0,0,0,0, 0,4'h0, 3, sc(0,0)));
      vecs.push_back(v("dw_ch1",   0,0,0,0, 0,4'h0, 1, sc(1,0)));
      vecs.push_back(v("dw_ch2",   0,0,0,0, 0,4'h0, 1, sc(2,0)));
      vecs.push_back(v("dw_ch3",   0,0,0,0, 0,4'h0, 1, sc(3,0)));
      vecs.push_back(v("dw_wrap",  0,0,0,0, 0,4'h0, 1, sc(0,1)));
      vecs.push_back(v("dw_stop",  0,1,0,0, 0,4'h0, 1, ZERO));
`ifdef CHAN_SKIP_EN
      // Channels 0 and 2 masked, dwell=1.
      vecs.push_back(v("sk_start", 1,0,0,0, 1,4'h5, 1, sc(1,0)));
      vecs.push_back(v("sk_a1",    0,0,0,0, 1,4'h5, 1, sc(1,0)));
      vecs.push_back(v("sk_a3",    0,0,0,0, 1,4'h5, 2, sc(3,0)));
      vecs.push_back(v("sk_w1",    0,0,0,0, 1,4'h5, 1, sc(1,1)));
      vecs.push_back(v("sk_b1",    0,0,0,0, 1,4'h5, 1, sc(1,0)));
      vecs.push_back(v("sk_b3",    0,0,0,0, 1,4'h5, 2, sc(3,0)));
      vecs.push_back(v("sk_w2",    0,0,0,0, 1,4'h5, 1, sc(1,1)));
      vecs.push_back(v("sk_stop",  0,1,0,0, 1,4'h5, 1, ZERO));
      // All masked at start: stays idle.
      vecs.push_back(v("sk_allF",  1,0,0,0, 1,4'hF, 3, ZERO));
      // All masked at an advance point: idle, no done.
      vecs.push_back(v("skF_start",1,0,0,1, 1,4'h0, 2, sc(0,0)));
      vecs.push_back(v("skF_adv",  0,0,0,1, 1,4'hF, 2, ZERO));
      // Single enabled channel, oneshot: wraps onto itself and completes.
      vecs.push_back(v("sk1_start",1,0,0,1, 0,4'hE, 1, sc(0,0)));
      vecs.push_back(v("sk1_done", 0,0,0,1, 0,4'hE, 1, DONE));
`endif

      // Asynchronous reset asserted between clock edges.
      #2 rst_n = 1'b0;
      #1 check("reset_async", ZERO);
      repeat (2) @(posedge clk);
      #1 check("reset_hold", ZERO);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

      // Reset mid-scan, then confirm nothing restarts without a new start.
      @(negedge clk);
      start = 1'b1; stop = 1'b0; pause = 1'b0; oneshot = 1'b0; dwell = 8'd3; skip_mask = 4'h0;
      @(posedge clk);
      #1 check("mid_pre", sc(0,0));
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("mid_async", ZERO);
      $display("txn reset mid-scan -> en=%0b in=%0d busy=%0b", en, in, busy);
      @(posedge clk);
      #1 check("mid_hold", ZERO);
      @(negedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 check("post_idle", ZERO);
      end
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 check("post_start", sc(0,0));
      @(negedge clk);
      start = 1'b0; stop = 1'b1;
      @(posedge clk);
      #1 check("post_stop", ZERO);
      $display("txn restart after reset -> en=%0b in=%0d busy=%0b", en, in, busy);
      @(negedge clk);
      stop = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
